// File: rtl/serial_adder_pkg.sv
// Shared constants for the slice-serial adder: FSM encoding, default
// geometry, and the helper that sizes the slice index.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2, never below 1 so a single-slice build still has an index bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// Combinational ripple of SLICE full-adder cells; also exposes the carry
// into the top cell so the caller can derive signed overflow.
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [SLICE:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
            assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co       = c[SLICE];
    assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/serial_adder.sv
// Slice-serial add/subtract: one SLICE-bit chunk per clock, low slice first,
// through a single shared adder_slice.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = clog2_min1(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] slice_x, slice_y, slice_s;
    logic             slice_co, slice_c_msb;

    assign slice_x = a_q[k_q*SLICE +: SLICE];
    assign slice_y = b_q[k_q*SLICE +: SLICE];

    adder_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .x        (slice_x),
        .y        (slice_y),
        .ci       (carry_q),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_c_msb)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_RUN: begin
                sum_d[k_q*SLICE +: SLICE] = slice_s;
                carry_d = slice_co;
                if (k_q == K_LAST) begin
                    // Flags only belong to the most significant slice.
                    cout_d  = slice_co;
                    ovf_d   = slice_c_msb ^ slice_co;
                    state_d = ST_DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start) begin
                    // Subtraction as A + ~B + 1, with cin acting as borrow-in.
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    k_d     = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
